// File: rtl/alu_pkg.sv
// Shared definitions for the ALU status unit.
// Holds the branch condition-code encoding, the bit position of each flag
// inside the 4-bit {N,Z,C,V} status word, and the result FSM state encoding.
package alu_pkg;

  // Bit positions of each flag inside the packed {N,Z,C,V} status word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Branch condition codes, ARM-style ordering
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Branch result FSM states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_status_unit_if.sv
// Bundle of the flag-write, branch-request and branch-result signals of the
// ALU status unit.
//   master : the ALU/pipeline side, which drives flag writes and branch
//            requests and consumes branch results
//   slave  : the status unit itself
// Flag word layout is {N,Z,C,V}.
interface alu_status_unit_if;
  import alu_pkg::*;

  // Flag write from the ALU
  logic       flag_we;
  logic [3:0] flag_mask;
  logic       V_in;
  logic       C_in;
  logic       N_in;
  logic       Z_in;
  logic [3:0] flags;
  logic       cin_out;

  // Branch request
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_ready;

  // Branch result
  logic       res_valid;
  logic       res_taken;
  logic [3:0] res_flags;
  logic       res_ready;

  modport master (
    output flag_we, flag_mask, V_in, C_in, N_in, Z_in,
    output br_valid, br_cond, res_ready,
    input  flags, cin_out, br_ready, res_valid, res_taken, res_flags
  );

  modport slave (
    input  flag_we, flag_mask, V_in, C_in, N_in, Z_in,
    input  br_valid, br_cond, res_ready,
    output flags, cin_out, br_ready, res_valid, res_taken, res_flags
  );

endinterface

// File: rtl/cond_eval.sv
// Pure combinational branch condition evaluator.
//   cond  : 4-bit condition code (see alu_pkg::cond_e)
//   flags : status word {N,Z,C,V}
//   taken : 1 when the condition holds for the given flags
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_unit.sv
// ALU status register plus branch-condition result channel.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of alu_status_unit_if
//              - flag_we/flag_mask/{N,Z,C,V}_in write the status flags
//              - flags/cin_out expose the registered status word and carry
//              - br_valid/br_cond/br_ready request a condition evaluation
//              - res_valid/res_taken/res_flags/res_ready return the result
module alu_status_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_status_unit_if.slave  bus
);

  logic [3:0] flag_reg;
  logic [3:0] alu_flags;
  logic [3:0] taken_flags;
  logic       taken_reg;
  logic       taken;
  logic       accept;
  state_e     state;
  state_e     state_next;

  assign alu_flags = {bus.N_in, bus.Z_in, bus.C_in, bus.V_in};

  // Requests are refused while a flag write is in flight so an evaluation
  // never sees flags that are about to change; also refused during reset.
  assign bus.br_ready = !rst && !bus.flag_we && (state == ST_IDLE || bus.res_ready);
  assign accept       = bus.br_valid && bus.br_ready;

  cond_eval u_cond_eval (
    .cond  (bus.br_cond),
    .flags (flag_reg),
    .taken (taken)
  );

  // Status register: masked per-bit update on flag_we
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg <= 4'b0000;
    end else if (bus.flag_we) begin
      flag_reg <= (bus.flag_mask & alu_flags) | (~bus.flag_mask & flag_reg);
    end
  end

  // Result capture: only an accepted request replaces the held result,
  // so flag writes during RESULT leave the snapshot untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_reg   <= 1'b0;
      taken_flags <= 4'b0000;
    end else if (accept) begin
      taken_reg   <= taken;
      taken_flags <= flag_reg;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and result-valid decode
  always_comb begin
    state_next    = state;
    bus.res_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready && !accept) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.flags     = flag_reg;
  assign bus.cin_out   = flag_reg[FLAG_C];
  assign bus.res_taken = taken_reg;
  assign bus.res_flags = taken_flags;

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed self-checking bench for alu_status_unit.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, well away from the active edge.
module tb_alu_status_unit;

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;
  logic [15:0] cond_table;

  alu_status_unit_if bus ();

  alu_status_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a flag write (flag_we held until changed by the caller)
  task automatic applyStimulus(input logic we, input logic [3:0] mask,
                               input logic [3:0] nzcv);
    bus.flag_we   = we;
    bus.flag_mask = mask;
    bus.N_in      = nzcv[3];
    bus.Z_in      = nzcv[2];
    bus.C_in      = nzcv[1];
    bus.V_in      = nzcv[0];
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    // Expected taken for cond 0..F with flags N=0,Z=1,C=0,V=1
    cond_table    = 16'h6A69;

    rst           = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    bus.br_valid  = 1'b0;
    bus.br_cond   = 4'h0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_flags",     bus.flags,     4'b0000);
    checkOutput("rst_res_valid", bus.res_valid, 1'b0);
    checkOutput("rst_br_ready",  bus.br_ready,  1'b0);
    checkOutput("rst_cin",       bus.cin_out,   1'b0);
    rst = 1'b0;
    #1;
    checkOutput("idle_br_ready", bus.br_ready, 1'b1);

    // Full-mask write, then carry-only write
    applyStimulus(1'b1, 4'b1111, 4'b0110);
    #1;
    checkOutput("we_blocks_ready", bus.br_ready, 1'b0);
    tick();
    checkOutput("flags_full", bus.flags,   4'b0110);
    checkOutput("cin_full",   bus.cin_out, 1'b1);
    applyStimulus(1'b1, 4'b0010, 4'b0100);
    tick();
    checkOutput("flags_cmask", bus.flags,   4'b0100);
    checkOutput("cin_cmask",   bus.cin_out, 1'b0);

    // Zero mask: no change, still blocks requests
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    #1;
    checkOutput("mask0_br_ready", bus.br_ready, 1'b0);
    tick();
    checkOutput("mask0_flags", bus.flags, 4'b0100);

    // Restore flags 0110 for HI/CS
    applyStimulus(1'b1, 4'b1111, 4'b0110);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("flags_0110", bus.flags, 4'b0110);

    // HI then CS, one-cycle latency each
    bus.br_valid  = 1'b1;
    bus.br_cond   = 4'h8;
    bus.res_ready = 1'b1;
    #1;
    checkOutput("hi_br_ready", bus.br_ready, 1'b1);
    tick();
    checkOutput("hi_valid",  bus.res_valid, 1'b1);
    checkOutput("hi_taken",  bus.res_taken, 1'b0);
    checkOutput("hi_rflags", bus.res_flags, 4'b0110);
    bus.br_cond = 4'h2;
    tick();
    checkOutput("cs_valid", bus.res_valid, 1'b1);
    checkOutput("cs_taken", bus.res_taken, 1'b1);
    bus.br_valid = 1'b0;
    tick();
    checkOutput("drain_valid", bus.res_valid, 1'b0);

    // Request colliding with a flag write waits and sees the new flags
    applyStimulus(1'b1, 4'b1111, 4'b1001);
    bus.br_valid = 1'b1;
    bus.br_cond  = 4'h4;
    #1;
    checkOutput("collide_br_ready", bus.br_ready, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    #1;
    checkOutput("collide_valid",  bus.res_valid, 1'b0);
    checkOutput("collide_flags",  bus.flags,     4'b1001);
    checkOutput("retry_br_ready", bus.br_ready,  1'b1);
    tick();
    checkOutput("mi_valid",  bus.res_valid, 1'b1);
    checkOutput("mi_taken",  bus.res_taken, 1'b1);
    checkOutput("mi_rflags", bus.res_flags, 4'b1001);

    // Back-to-back GE then LT with N=1,V=1
    bus.br_cond = 4'hA;
    tick();
    checkOutput("ge_valid", bus.res_valid, 1'b1);
    checkOutput("ge_taken", bus.res_taken, 1'b1);
    bus.br_cond = 4'hB;
    tick();
    checkOutput("lt_valid", bus.res_valid, 1'b1);
    checkOutput("lt_taken", bus.res_taken, 1'b0);

    // Hold result for 3 cycles with res_ready low; flag write mid-hold
    bus.br_cond   = 4'hE;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) applyStimulus(1'b1, 4'b1111, 4'b0000);
      else        applyStimulus(1'b0, 4'b0000, 4'b0000);
      #1;
      checkOutput("hold_br_ready", bus.br_ready, 1'b0);
      tick();
      checkOutput("hold_valid",  bus.res_valid, 1'b1);
      checkOutput("hold_taken",  bus.res_taken, 1'b0);
      checkOutput("hold_rflags", bus.res_flags, 4'b1001);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("hold_we_flags", bus.flags, 4'b0000);
    bus.res_ready = 1'b1;
    #1;
    checkOutput("release_br_ready", bus.br_ready, 1'b1);
    tick();
    checkOutput("al_taken",  bus.res_taken, 1'b1);
    checkOutput("al_rflags", bus.res_flags, 4'b0000);

    // Sweep all condition codes with flags N=0,Z=1,C=0,V=1
    bus.br_valid = 1'b0;
    applyStimulus(1'b1, 4'b1111, 4'b0101);
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("sweep_flags", bus.flags, 4'b0101);
    bus.br_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.br_cond = 4'(i);
      tick();
      checkOutput($sformatf("sweep_cond_%0h", i), bus.res_taken, cond_table[i]);
    end

    // Reset mid-RESULT overrides a pending write and accept
    bus.res_ready = 1'b0;
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_br_ready", bus.br_ready, 1'b0);
    tick();
    rst = 1'b0;
    bus.br_valid = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    #1;
    checkOutput("post_rst_valid",  bus.res_valid, 1'b0);
    checkOutput("post_rst_flags",  bus.flags,     4'b0000);
    checkOutput("post_rst_taken",  bus.res_taken, 1'b0);
    checkOutput("post_rst_rflags", bus.res_flags, 4'b0000);
    checkOutput("post_rst_cin",    bus.cin_out,   1'b0);
    checkOutput("post_rst_ready",  bus.br_ready,  1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
